// File: rtl/rv_mc_ctrl.sv
// Multicycle control FSM for the RV32I-subset core: sequences one shared ALU
// through fetch/decode/execute/memory/writeback and drives the datapath enables.
module rv_mc_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [2:0] w_alu_ctrl;
  logic [2:0] w_funct_ctrl;
  logic [1:0] w_imm_src;
  logic       w_done;
  logic       w_illegal_pulse;
  logic       w_halted;
  logic       w_f3_alu_ok;
  logic       w_legal;

  // Instruction legality check, evaluated only while in DECODE.
  assign w_f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                       (funct3 == 3'b110) || (funct3 == 3'b111);
  assign w_legal = (((op == OP_LW) || (op == OP_SW)) && (funct3 == 3'b010)) ||
                   (((op == OP_R)  || (op == OP_I))  && w_f3_alu_ok)        ||
                   ((op == OP_BEQ) && (funct3 == 3'b000))                    ||
                   (op == OP_JAL);

  always_comb begin
    w_funct_ctrl = ALU_ADD;
    case (funct3)
      3'b000:  w_funct_ctrl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_funct_ctrl = ALU_SLT;
      3'b110:  w_funct_ctrl = ALU_OR;
      3'b111:  w_funct_ctrl = ALU_AND;
      default: w_funct_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    w_imm_src = 2'b00;
    case (op)
      OP_LW, OP_I: w_imm_src = 2'b00;
      OP_SW:       w_imm_src = 2'b01;
      OP_BEQ:      w_imm_src = 2'b10;
      OP_JAL:      w_imm_src = 2'b11;
      default:     w_imm_src = 2'b00;
    endcase
  end

  // NOTE: state uses non-blocking assignment; the async reset aborts any instruction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    w_next_state    = r_state;
    w_pc_update     = 1'b0;
    w_branch        = 1'b0;
    w_adr_src       = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_result_src    = 2'b00;
    w_src_a         = 2'b00;
    w_src_b         = 2'b00;
    w_alu_ctrl      = ALU_ADD;
    w_done          = 1'b0;
    w_illegal_pulse = 1'b0;
    w_halted        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        w_pc_update  = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_src_a = 2'b01;
        w_src_b = 2'b01;
        if (!w_legal) begin
          w_illegal_pulse = 1'b1;
          w_next_state    = ILLEGAL_HALT ? S_HALT : S_FETCH;
        end else begin
          case (op)
            OP_LW, OP_SW: w_next_state = S_MEMADR;
            OP_R:         w_next_state = S_EXECR;
            OP_I:         w_next_state = S_EXECI;
            OP_BEQ:       w_next_state = S_BEQ;
            default:      w_next_state = S_JAL;
          endcase
        end
      end
      S_MEMADR: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b01;
        w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src    = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_done       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXECR: begin
        w_src_a      = 2'b10;
        w_alu_ctrl   = w_funct_ctrl;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b01;
        w_alu_ctrl   = w_funct_ctrl;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BEQ: begin
        w_src_a      = 2'b10;
        w_alu_ctrl   = ALU_SUB;
        w_branch     = 1'b1;
        w_done       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        w_src_a      = 2'b01;
        w_src_b      = 2'b10;
        w_pc_update  = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_HALT: begin
        w_halted     = 1'b1;
        w_next_state = S_HALT;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // Write enables are gated by rst_n so nothing can be written while reset is held.
  assign pc_write      = rst_n & (w_pc_update | (w_branch & zero));
  assign ir_write      = rst_n & w_ir_write;
  assign mem_write     = rst_n & w_mem_write;
  assign reg_write     = rst_n & w_reg_write;
  assign adr_src       = w_adr_src;
  assign result_src    = w_result_src;
  assign alu_src_a     = w_src_a;
  assign alu_src_b     = w_src_b;
  assign imm_src       = w_imm_src;
  assign alu_ctrl      = w_alu_ctrl;
  assign instr_done    = w_done;
  assign illegal_instr = w_illegal_pulse;
  assign halted        = w_halted;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Scoreboard bench for rv_mc_ctrl: per-cycle expected control vectors are queued
// per instruction and compared against a refetching and a halting instance.
module tb_rv_mc_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_ctrl;
    logic       done;
    logic       ill;
    logic       halted;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pc_write_0, adr_src_0, mem_write_0, ir_write_0, reg_write_0;
  logic [1:0] result_src_0, alu_src_a_0, alu_src_b_0, imm_src_0;
  logic [2:0] alu_ctrl_0;
  logic       instr_done_0, illegal_instr_0, halted_0;
  logic       pc_write_1, adr_src_1, mem_write_1, ir_write_1, reg_write_1;
  logic [1:0] result_src_1, alu_src_a_1, alu_src_b_1, imm_src_1;
  logic [2:0] alu_ctrl_1;
  logic       instr_done_1, illegal_instr_1, halted_1;

  vec_t q0[$];
  vec_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv_mc_ctrl #(.ILLEGAL_HALT(1'b0)) dut_refetch (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write_0), .adr_src(adr_src_0), .mem_write(mem_write_0),
    .ir_write(ir_write_0), .reg_write(reg_write_0), .result_src(result_src_0),
    .alu_src_a(alu_src_a_0), .alu_src_b(alu_src_b_0), .imm_src(imm_src_0),
    .alu_ctrl(alu_ctrl_0), .instr_done(instr_done_0), .illegal_instr(illegal_instr_0),
    .halted(halted_0)
  );

  rv_mc_ctrl #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write_1), .adr_src(adr_src_1), .mem_write(mem_write_1),
    .ir_write(ir_write_1), .reg_write(reg_write_1), .result_src(result_src_1),
    .alu_src_a(alu_src_a_1), .alu_src_b(alu_src_b_1), .imm_src(imm_src_1),
    .alu_ctrl(alu_ctrl_1), .instr_done(instr_done_1), .illegal_instr(illegal_instr_1),
    .halted(halted_1)
  );

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b_%b_%b_%b_%b rs=%b a=%b b=%b imm=%b alu=%b done=%b ill=%b halt=%b exp=%b_%b_%b_%b_%b rs=%b a=%b b=%b imm=%b alu=%b done=%b ill=%b halt=%b",
               tag, got.pc_write, got.adr_src, got.mem_write, got.ir_write, got.reg_write,
               got.result_src, got.src_a, got.src_b, got.imm_src, got.alu_ctrl, got.done,
               got.ill, got.halted, exp.pc_write, exp.adr_src, exp.mem_write, exp.ir_write,
               exp.reg_write, exp.result_src, exp.src_a, exp.src_b, exp.imm_src,
               exp.alu_ctrl, exp.done, exp.ill, exp.halted);
    end
  endtask

  function automatic vec_t obs0();
    return vec_t'({pc_write_0, adr_src_0, mem_write_0, ir_write_0, reg_write_0, result_src_0,
                   alu_src_a_0, alu_src_b_0, imm_src_0, alu_ctrl_0, instr_done_0,
                   illegal_instr_0, halted_0});
  endfunction

  function automatic vec_t obs1();
    return vec_t'({pc_write_1, adr_src_1, mem_write_1, ir_write_1, reg_write_1, result_src_1,
                   alu_src_a_1, alu_src_b_1, imm_src_1, alu_ctrl_1, instr_done_1,
                   illegal_instr_1, halted_1});
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 2'b00;
      7'b0100011:             return 2'b01;
      7'b1100011:             return 2'b10;
      7'b1101111:             return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] fn_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      7'b0000011, 7'b0100011: return f3 == 3'b010;
      7'b0110011, 7'b0010011: return f3 inside {3'b000, 3'b010, 3'b110, 3'b111};
      7'b1100011:             return f3 == 3'b000;
      7'b1101111:             return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic vec_t base(input logic [6:0] o);
    vec_t v;
    v = '0;
    v.imm_src = imm_of(o);
    return v;
  endfunction

  function automatic vec_t fetch_vec(input logic [6:0] o);
    vec_t v;
    v = base(o);
    v.pc_write = 1'b1; v.ir_write = 1'b1; v.src_b = 2'b10; v.result_src = 2'b10;
    return v;
  endfunction

  function automatic vec_t reset_vec(input logic [6:0] o);
    vec_t v;
    v = fetch_vec(o);
    v.pc_write = 1'b0; v.ir_write = 1'b0;
    return v;
  endfunction

  task automatic push_both(input vec_t v);
    q0.push_back(v);
    q1.push_back(v);
  endtask

  // Expected per-cycle vectors for one instruction, starting in FETCH.
  task automatic push_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    vec_t f, d, v, w, h;
    f = fetch_vec(o);
    d = base(o); d.src_a = 2'b01; d.src_b = 2'b01;
    if (!legal(o, f3)) begin
      d.ill = 1'b1;
      h = base(o); h.halted = 1'b1;
      for (int i = 0; i < 3; i++) begin q0.push_back(f); q0.push_back(d); end
      q1.push_back(f); q1.push_back(d);
      for (int i = 0; i < 4; i++) q1.push_back(h);
      return;
    end
    push_both(f);
    push_both(d);
    w = base(o); w.reg_write = 1'b1; w.done = 1'b1;
    case (o)
      7'b0000011: begin
        v = base(o); v.src_a = 2'b10; v.src_b = 2'b01; push_both(v);
        v = base(o); v.adr_src = 1'b1; push_both(v);
        v = base(o); v.result_src = 2'b01; v.reg_write = 1'b1; v.done = 1'b1; push_both(v);
      end
      7'b0100011: begin
        v = base(o); v.src_a = 2'b10; v.src_b = 2'b01; push_both(v);
        v = base(o); v.adr_src = 1'b1; v.mem_write = 1'b1; v.done = 1'b1; push_both(v);
      end
      7'b0110011: begin
        v = base(o); v.src_a = 2'b10; v.alu_ctrl = fn_of(o, f3, f7); push_both(v);
        push_both(w);
      end
      7'b0010011: begin
        v = base(o); v.src_a = 2'b10; v.src_b = 2'b01; v.alu_ctrl = fn_of(o, f3, f7); push_both(v);
        push_both(w);
      end
      7'b1100011: begin
        v = base(o); v.src_a = 2'b10; v.alu_ctrl = 3'b001; v.pc_write = z; v.done = 1'b1;
        push_both(v);
      end
      default: begin
        v = base(o); v.src_a = 2'b01; v.src_b = 2'b10; v.pc_write = 1'b1; push_both(v);
        push_both(w);
      end
    endcase
  endtask

  // Entered just after a falling edge with both instances in FETCH. n_cmp>0 stops
  // after that many cycles (for a mid-instruction reset) without advancing time.
  task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input int n_cmp);
    vec_t e0, e1;
    int k;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    push_instr(o, f3, f7, z);
    k = 0;
    while (q0.size() > 0) begin
      #1;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check($sformatf("%s_c%0d_refetch", tag, k + 1), obs0(), e0);
      check($sformatf("%s_c%0d_halt", tag, k + 1), obs1(), e1);
      k++;
      if (n_cmp != 0 && k == n_cmp) begin
        q0.delete();
        q1.delete();
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst_n = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      check($sformatf("%s_rst%0d_refetch", tag, c), obs0(), reset_vec(op));
      check($sformatf("%s_rst%0d_halt", tag, c), obs1(), reset_vec(op));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0;
    do_reset("por", 3);
    run("r_sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 0);
    run("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 0);
    run("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 0);
    run("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 0);
    run("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 0);
    run("slti",   7'b0010011, 3'b010, 1'b0, 1'b0, 0);
    run("ori",    7'b0010011, 3'b110, 1'b0, 1'b0, 0);
    run("andi",   7'b0010011, 3'b111, 1'b0, 1'b0, 0);
    run("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 0);
    run("r_add",  7'b0110011, 3'b000, 1'b0, 1'b1, 0);
    run("r_slt",  7'b0110011, 3'b010, 1'b1, 1'b0, 0);
    run("r_or",   7'b0110011, 3'b110, 1'b0, 1'b0, 0);
    run("r_and",  7'b0110011, 3'b111, 1'b0, 1'b0, 0);
    run("jal",    7'b1101111, 3'b101, 1'b1, 1'b0, 0);
    run("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 3);
    do_reset("abort", 2);
    run("sw_after_abort", 7'b0100011, 3'b010, 1'b0, 1'b0, 0);
    run("ill_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 0);
    do_reset("ill_op", 2);
    run("lw_bad_f3", 7'b0000011, 3'b000, 1'b0, 1'b0, 0);
    do_reset("lw_bad_f3", 1);
    run("beq_bad_f3", 7'b1100011, 3'b001, 1'b0, 1'b1, 0);
    do_reset("beq_bad_f3", 1);
    run("r_f3_001", 7'b0110011, 3'b001, 1'b0, 1'b0, 0);
    do_reset("r_f3_001", 1);
    run("r_sub_end", 7'b0110011, 3'b000, 1'b1, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_mc_ctrl.md
Name: rv_mc_ctrl

Overview:
- Multicycle control unit for the RV32I subset core.
- Sequences the shared 32-bit ALU (add/sub/and/or/slt) across fetch, decode, execute, memory and writeback cycles. It drives the ALU operation code, operand selects, memory/register/PC write enables and result muxing.
- Sits between the instruction register fields and the datapath. Every instruction reuses the one ALU for PC+4, address, branch and arithmetic computation.

Parameters:
ILLEGAL_HALT, 0, 0: illegal instruction pulses illegal_instr and refetches; 1: enter HALT until reset.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  instruction opcode (instr[6:0])
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
pc_write  output  1  PC register load enable
adr_src  output  1  memory address select: 0 PC, 1 result
mem_write  output  1  data memory write enable
ir_write  output  1  instruction/old-PC register load enable
reg_write  output  1  register file write enable
result_src  output  2  00 ALUOut reg, 01 read data reg, 10 ALU result (live)
alu_src_a  output  2  00 PC, 01 oldPC, 10 rs1 reg
alu_src_b  output  2  00 rs2 reg, 01 immediate, 10 constant 4
imm_src  output  2  00 I, 01 S, 10 B, 11 J
alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
instr_done  output  1  one-cycle pulse in last state of each instruction
illegal_instr  output  1  one-cycle pulse on illegal decode
halted  output  1  high in HALT state

Behaviour:
- Reset: async, state <= FETCH. While rst_n low, pc_write, ir_write, mem_write and reg_write are forced 0. All other outputs show FETCH values. On release, the first rising edge executes FETCH.
- Outputs are decoded from state (Moore), except pc_write = pc_update | (branch & zero).
- Default for every output not listed in a state: 0.
- imm_src is decoded from op in every state: I for 0000011/0010011, S for 0100011, B for 1100011, J for 1101111, 00 otherwise.
- States and outputs:
  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, aluop=add, result_src=10, pc_update=1. Next: DECODE.
  - DECODE: src_a=01, src_b=01, aluop=add (branch target into ALUOut).
    - lw/sw -> MEMADR; R (0110011) -> EXECR; I-ALU (0010011) -> EXECI; beq (1100011) -> BEQ; jal (1101111) -> JAL.
    - Illegal -> pulse illegal_instr, then FETCH, or HALT if ILLEGAL_HALT=1.
  - MEMADR: src_a=10, src_b=01, add. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: result_src=00, adr_src=1. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_done=1. Next: FETCH.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1, instr_done=1. Next: FETCH.
  - EXECR: src_a=10, src_b=00, aluop=funct. Next: ALUWB.
  - EXECI: src_a=10, src_b=01, aluop=funct. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_done=1. Next: FETCH.
  - BEQ: src_a=10, src_b=00, aluop=sub, result_src=00, branch=1, instr_done=1. Next: FETCH.
  - JAL: src_a=01, src_b=10, add, result_src=00, pc_update=1. Next: ALUWB.
  - HALT: all enables 0, halted=1. Stays until reset.
- ALU decode:
  - aluop add -> 000; sub -> 001.
  - funct: funct3 000 -> 001 if (op[5] & funct7b5) else 000; 010 -> 101; 110 -> 011; 111 -> 010.
- Illegal when any of:
  - op is not one of the six listed.
  - R/I with funct3 not in {000, 010, 110, 111}.
  - lw/sw funct3 != 010.
  - beq funct3 != 000.
- Latency in cycles: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- The sub/add choice for I-type ignores funct7b5 (op[5]=0).
- Reset asserted mid-instruction: the state aborts immediately, with no partial writes after assertion.

Test Plan:
- Reset held 3 cycles, then released with op=0110011, f3=000, f7b5=1 → enables 0 during reset. FETCH asserts pc_write=1, ir_write=1, alu_ctrl=000. EXECR shows alu_ctrl=001. ALUWB shows reg_write=1 and instr_done=1 at cycle 4.
- lw (op=0000011, f3=010) → exactly 5 cycles. MEMADR shows src_a=10, src_b=01, imm_src=00. MEMWB shows result_src=01, reg_write=1. mem_write never asserted.
- sw (op=0100011, f3=010) → 4 cycles. MEMWRITE shows mem_write=1, adr_src=1, imm_src=01. reg_write never asserted.
- beq, BEQ cycle, once with zero=1 and once with zero=0 → pc_write=1 and pc_write=0 respectively. alu_ctrl=001, instr_done=1 at cycle 3.
- Illegal op=1111111 with ILLEGAL_HALT=0 → illegal_instr pulse in cycle 2, FETCH in cycle 3. With ILLEGAL_HALT=1 → halted=1 and all enables stay 0 until rst_n low.
- I-type slti/ori/andi (f3=010/110/111) → alu_ctrl 101/011/010 in EXECI. An R-type with f3=001 → illegal_instr.
